// File: rtl/priority_encoder_queued.sv
// Queued priority encoder: sticky pending request bits presented one at a time as a
// binary index over a valid/ready handshake, with fixed MSB-first or round-robin priority.
module priority_encoder_queued #(
  parameter  int N_LINES = 8,
  parameter  int MODE    = 0,
  localparam int OUT_W   = $clog2(N_LINES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] in_lines,
  input  logic               clr_all,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_lines,
  output logic [N_LINES-1:0] pending,
  output logic               dup_hit
);

  logic [N_LINES-1:0] r_pending;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_lines;
  logic [OUT_W-1:0]   r_rr_last;
  logic               r_dup_hit;

  logic               w_ack;
  logic               w_load;
  logic [N_LINES-1:0] w_ack_vec;
  logic [N_LINES-1:0] w_pending_nxt;
  logic [OUT_W-1:0]   w_rr_eff;
  logic [OUT_W-1:0]   w_sel_all;
  logic [OUT_W-1:0]   w_sel_low;
  logic               w_low_found;
  logic               w_any_nxt;
  logic [OUT_W-1:0]   w_sel;

  assign w_ack  = r_out_valid & out_ready;
  assign w_load = ~r_out_valid | w_ack;

  // The pointer used for this cycle's search already reflects an ack happening now,
  // so back-to-back grants rotate instead of re-granting the same line.
  assign w_rr_eff = w_ack ? r_out_lines : r_rr_last;

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (latch).
    w_ack_vec = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (w_ack && (r_out_lines == OUT_W'(i))) w_ack_vec[i] = 1'b1;
    end
  end

  // Set wins over the ack clear, so a re-request in the ack cycle stays pending.
  assign w_pending_nxt = (r_pending & ~w_ack_vec) | in_lines;
  assign w_any_nxt     = |w_pending_nxt;

  // Descending search from rr-1 wrapping at 0 == highest set index below the pointer,
  // else highest set index overall. A zero pointer admits every index.
  always_comb begin
    w_sel_all   = '0;
    w_sel_low   = '0;
    w_low_found = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      if (w_pending_nxt[i]) begin
        w_sel_all = OUT_W'(i);
        if ((w_rr_eff == '0) || (OUT_W'(i) < w_rr_eff)) begin
          w_sel_low   = OUT_W'(i);
          w_low_found = 1'b1;
        end
      end
    end
  end

  assign w_sel = ((MODE == 1) && w_low_found) ? w_sel_low : w_sel_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_lines <= '0;
      r_rr_last   <= '0;
      r_dup_hit   <= 1'b0;
    end else if (clr_all) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_lines <= '0;
      r_rr_last   <= '0;
      r_dup_hit   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_dup_hit <= |(in_lines & r_pending & ~w_ack_vec);
      if (w_ack) r_rr_last <= r_out_lines;
      if (w_load) begin
        r_out_valid <= w_any_nxt;
        // When nothing is pending the index keeps its last value.
        if (w_any_nxt) r_out_lines <= w_sel;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_lines = r_out_lines;
  assign pending   = r_pending;
  assign dup_hit   = r_dup_hit;

endmodule

// File: tb/tb_priority_encoder_queued.sv
// Self-checking bench: four encoder configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus hand-computed directed checks.
module tb_priority_encoder_queued;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] stim;
  logic       clr_all;
  logic       out_ready;
  bit         cmp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic       v0, v1, v2, v3;
  logic [1:0] l0;
  logic [2:0] l1, l2, l3;
  logic [3:0] p0;
  logic [7:0] p1, p2;
  logic [4:0] p3;
  logic       dh0, dh1, dh2, dh3;

  always #5 clk = ~clk;

  priority_encoder_queued #(.N_LINES(4), .MODE(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_lines(stim[3:0]), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v0), .out_lines(l0), .pending(p0), .dup_hit(dh0));
  priority_encoder_queued #(.N_LINES(8), .MODE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_lines(stim), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v1), .out_lines(l1), .pending(p1), .dup_hit(dh1));
  priority_encoder_queued #(.N_LINES(8), .MODE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_lines(stim), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v2), .out_lines(l2), .pending(p2), .dup_hit(dh2));
  priority_encoder_queued #(.N_LINES(5), .MODE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_lines(stim[4:0]), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v3), .out_lines(l3), .pending(p3), .dup_hit(dh3));

  // ---------------- behavioural model ----------------
  logic [7:0] m_pend  [NDUT];
  bit         m_valid [NDUT];
  int         m_lines [NDUT];
  int         m_rr    [NDUT];
  bit         m_dup   [NDUT];

  function automatic int n_of(input int k);
    case (k)
      0:       return 4;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int mode_of(input int k);
    return (k >= 2) ? 1 : 0;
  endfunction

  // Priority order: fixed = n-1 down to 0; rotating = rr-1, rr-2, ... modulo n.
  function automatic int pick(input logic [7:0] p, input int n, input int mode, input int rr);
    if (mode == 0) begin
      for (int i = n - 1; i >= 0; i--) if (p[i[2:0]]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int idx;
        idx = (((rr - k) % n) + n) % n;
        if (p[idx[2:0]]) return idx;
      end
    end
    return 0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_pend[k] = '0; m_valid[k] = 1'b0; m_lines[k] = 0; m_rr[k] = 0; m_dup[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k);
    int         n;
    logic [7:0] in_m;
    logic [7:0] nxt;
    bit         ack;
    bit         dup;
    n    = n_of(k);
    in_m = stim & 8'((1 << n) - 1);
    if (clr_all) begin
      m_pend[k] = '0; m_valid[k] = 1'b0; m_lines[k] = 0; m_rr[k] = 0; m_dup[k] = 1'b0;
      return;
    end
    ack = m_valid[k] && out_ready;
    nxt = m_pend[k];
    if (ack) nxt[m_lines[k][2:0]] = 1'b0;
    dup = 1'b0;
    for (int i = 0; i < n; i++) if (in_m[i[2:0]] && nxt[i[2:0]]) dup = 1'b1;
    nxt = nxt | in_m;
    if (ack) m_rr[k] = m_lines[k];
    if (!m_valid[k] || ack) begin
      m_valid[k] = (nxt != '0);
      if (nxt != '0) m_lines[k] = pick(nxt, n, mode_of(k), m_rr[k]);
    end
    m_pend[k] = nxt;
    m_dup[k]  = dup;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < NDUT; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [31:0] l,
                     input logic [31:0] p, input logic d);
    check($sformatf("d%0d.out_valid", k), 32'(v), 32'(m_valid[k]));
    check($sformatf("d%0d.out_lines", k), l, 32'(m_lines[k]));
    check($sformatf("d%0d.pending", k), p, 32'(m_pend[k]));
    check($sformatf("d%0d.dup_hit", k), 32'(d), 32'(m_dup[k]));
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      cmp(0, v0, 32'(l0), 32'(p0), dh0);
      cmp(1, v1, 32'(l1), 32'(p1), dh1);
      cmp(2, v2, 32'(l2), 32'(p2), dh2);
      cmp(3, v3, 32'(l3), 32'(p3), dh3);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; stim = '0; clr_all = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_valid", 32'(v0), 0);
    check("rst_lines", 32'(l2), 0);
    check("rst_pending", 32'(p1), 0);
    check("rst_dup", 32'(dh3), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Legacy single pulses, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stim = 8'(1 << i);
      tick();
      stim = '0;
      check("legacy_valid", 32'(v0), 1);
      check("legacy_lines", 32'(l0), 32'(i));
      tick();
      check("legacy_empty", 32'(v0), 0);
      tick(18);
    end
    check("legacy_pending", 32'(p0), 0);

    // Simultaneous requests drain in priority order
    stim = 8'h0A;
    tick();
    stim = '0;
    check("simul_first", 32'(l0), 3);
    tick();
    check("simul_second", 32'(l0), 1);
    check("simul_second_v", 32'(v0), 1);
    tick();
    check("simul_empty", 32'(v0), 0);

    // Backpressure holds the presented index
    out_ready = 1'b0;
    stim = 8'h01;
    tick();
    stim = '0;
    check("bp_first", 32'(l0), 0);
    tick();
    stim = 8'h08;
    tick();
    stim = '0;
    check("bp_hold", 32'(l0), 0);
    check("bp_pending", 32'(p0), 9);
    tick(2);
    check("bp_still", 32'(l0), 0);
    out_ready = 1'b1;
    tick();
    check("bp_next", 32'(l0), 3);
    check("bp_next_v", 32'(v0), 1);
    tick();
    check("bp_empty", 32'(v0), 0);

    // Duplicate detection and re-request during ack
    out_ready = 1'b0;
    stim = 8'h04;
    tick();
    stim = '0;
    check("dup_none", 32'(dh0), 0);
    check("dup_pres", 32'(l0), 2);
    stim = 8'h04;
    tick();
    stim = '0;
    check("dup_pulse", 32'(dh0), 1);
    tick();
    check("dup_gone", 32'(dh0), 0);
    out_ready = 1'b1;
    stim = 8'h04;
    tick();
    stim = '0;
    check("reack_dup", 32'(dh0), 0);
    check("reack_valid", 32'(v0), 1);
    check("reack_lines", 32'(l0), 2);
    tick();
    check("reack_empty", 32'(v0), 0);

    // Fairness with every line held high
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    stim = 8'hFF;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("fair_fixed", 32'(l1), 7);
      check("fair_rr8", 32'(l2), 32'(7 - (c % 8)));
      check("fair_rr5", 32'(l3), 32'(4 - (c % 5)));
      if (c < 3) check("pin_model_rr8", 32'(m_lines[2]), 32'(7 - c));
    end
    stim = '0;
    tick(12);

    // Clear beats ack and new requests in the same cycle
    out_ready = 1'b0;
    stim = 8'h08;
    tick();
    stim = '0;
    check("clr_pre", 32'(v0), 1);
    clr_all = 1'b1; stim = 8'h06; out_ready = 1'b1;
    tick();
    clr_all = 1'b0; stim = '0;
    check("clr_valid", 32'(v0), 0);
    check("clr_pending", 32'(p0), 0);
    check("clr_lines", 32'(l0), 0);
    check("clr_pending8", 32'(p2), 0);
    tick();
    check("clr_dropped", 32'(v1), 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      stim      = 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_all   = ($urandom_range(0, 99) == 0);
      tick();
    end
    stim = '0; clr_all = 1'b0;
    tick(12);

    // Asynchronous reset aborts a pending handshake
    out_ready = 1'b0;
    stim = 8'h08;
    tick();
    stim = '0;
    check("ar_pre_v", 32'(v0), 1);
    check("ar_pre_l", 32'(l0), 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(v0), 0);
    check("ar_lines", 32'(l0), 0);
    check("ar_pending", 32'(p0), 0);
    check("ar_valid8", 32'(v2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("ar_after", 32'(v0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
